// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter for a single-port registered-read memory
// Zero-latency grant, one access per cycle, per-port read strobes and saturating grant counters.
module mem_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic             wen0,
  input  logic             wen1,
  input  logic [AW-1:0]    addr0,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [WIDTH-1:0] rdata,
  output logic             mem_wen,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             cnt_clr,
  output logic [15:0]      gnt_cnt0,
  output logic [15:0]      gnt_cnt1
);

  logic prio;

  // Grants are gated by rst_n so nothing is accepted while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (req0 && (!req1 || !prio)) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  always_comb begin
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_wen   = wen0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_wen   = wen1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  assign rdata = mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      if (gnt0) begin
        prio <= 1'b1;
      end else if (gnt1) begin
        prio <= 1'b0;
      end
      rvalid0 <= gnt0 && !wen0;
      rvalid1 <= gnt1 && !wen1;
    end
  end

  // Clear wins over a same-edge increment; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0 <= 16'h0000;
      gnt_cnt1 <= 16'h0000;
    end else if (cnt_clr) begin
      gnt_cnt0 <= 16'h0000;
      gnt_cnt1 <= 16'h0000;
    end else begin
      if (gnt0 && gnt_cnt0 != 16'hFFFF) begin
        gnt_cnt0 <= gnt_cnt0 + 16'h0001;
      end
      if (gnt1 && gnt_cnt1 != 16'hFFFF) begin
        gnt_cnt1 <= gnt_cnt1 + 16'h0001;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a behavioural memory and read scoreboard
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0, req1, wen0, wen1, cnt_clr;
  logic [2:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1, mem_wen;
  logic [7:0] rdata, mem_wdata, mem_rdata;
  logic [2:0] mem_addr;
  logic [15:0] gnt_cnt0, gnt_cnt1;

  int checks = 0;
  int errors = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  // Memory starts with word a = 8'h40 + a.
  logic [7:0] mem [8] = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47};

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(8), .DEPTH(8), .AW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .wen0(wen0), .wen1(wen1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cnt_clr(cnt_clr), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr] <= mem_wdata;
    else         mem_rdata <= mem[mem_addr];
  end

  // Read responses are popped from per-port queues filled when a read grant is expected.
  always @(negedge clk) begin
    if (rvalid0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++; $display("FAIL rvalid0_unexpected got 1 want 0");
      end else begin
        logic [7:0] e0;
        e0 = q0.pop_front();
        if (rdata !== e0) begin errors++; $display("FAIL rdata0 got %0h want %0h", rdata, e0); end
      end
    end
    if (rvalid1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++; $display("FAIL rvalid1_unexpected got 1 want 0");
      end else begin
        logic [7:0] e1;
        e1 = q1.pop_front();
        if (rdata !== e1) begin errors++; $display("FAIL rdata1 got %0h want %0h", rdata, e1); end
      end
    end
  end

  task automatic idle();
    req0 = 0; req1 = 0; wen0 = 0; wen1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; cnt_clr = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    @(posedge clk); @(posedge clk); #1;
    q0.delete(); q1.delete();
    rst_n = 1;
  endtask

  task automatic settle();
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle();
    req0 = 1; wen0 = 1; addr0 = 3'd2; wdata0 = 8'hFF;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, mem_wen} !== 3'b000) begin
      errors++; $display("FAIL reset_gnt got %b want 000", {gnt0, gnt1, mem_wen});
    end
    checks++;
    if ({rvalid0, rvalid1, gnt_cnt0, gnt_cnt1} !== 34'd0) begin
      errors++; $display("FAIL reset_state got %0h want 0", {rvalid0, rvalid1, gnt_cnt0, gnt_cnt1});
    end
    idle();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_write_read();
    do_reset();
    req0 = 1; wen0 = 1; addr0 = 3'd3; wdata0 = 8'hA5;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, mem_wen, mem_addr, mem_wdata} !== {1'b1, 1'b0, 1'b1, 3'd3, 8'hA5}) begin
      errors++; $display("FAIL wr_cmd got %0h want %0h", {gnt0, gnt1, mem_wen, mem_addr, mem_wdata},
                         {1'b1, 1'b0, 1'b1, 3'd3, 8'hA5});
    end
    @(posedge clk); #1;
    wen0 = 0; wdata0 = 8'h00;
    q0.push_back(8'hA5);
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, mem_wen, mem_addr} !== {1'b1, 1'b0, 1'b0, 3'd3}) begin
      errors++; $display("FAIL rd_cmd got %0h want %0h", {gnt0, gnt1, mem_wen, mem_addr}, {1'b1, 1'b0, 1'b0, 3'd3});
    end
    checks++;
    if (rvalid0 !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid got %b want 0", rvalid0); end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    checks++;
    if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0) begin
      errors++; $display("FAIL rd_rvalid got %b%b want 10", rvalid0, rvalid1);
    end
    checks++;
    if ({mem_wen, mem_addr, mem_wdata} !== 12'd0) begin
      errors++; $display("FAIL idle_mem got %0h want 0", {mem_wen, mem_addr, mem_wdata});
    end
    checks++;
    if (gnt_cnt0 !== 16'd2) begin errors++; $display("FAIL wr_rd_cnt0 got %0d want 2", gnt_cnt0); end
    settle();
    checks++;
    if (q0.size() != 0) begin errors++; $display("FAIL wr_rd_drain got %0d want 0", q0.size()); end
  endtask

  task automatic test_alternate();
    do_reset();
    req0 = 1; addr0 = 3'd1; req1 = 1; addr1 = 3'd6;
    for (int c = 0; c < 4; c++) begin
      logic exp0;
      exp0 = (c % 2 == 0);
      if (exp0) q0.push_back(8'h41); else q1.push_back(8'h46);
      @(negedge clk);
      checks++;
      if (gnt0 !== exp0 || gnt1 !== !exp0) begin
        errors++; $display("FAIL alt_gnt c%0d got %b%b want %b%b", c, gnt0, gnt1, exp0, !exp0);
      end
      checks++;
      if (mem_addr !== (exp0 ? 3'd1 : 3'd6)) begin
        errors++; $display("FAIL alt_addr c%0d got %0d want %0d", c, mem_addr, exp0 ? 1 : 6);
      end
      if (c > 0) begin
        checks++;
        if (rvalid0 !== !exp0 || rvalid1 !== exp0) begin
          errors++; $display("FAIL alt_rvalid c%0d got %b%b want %b%b", c, rvalid0, rvalid1, !exp0, exp0);
        end
      end
      @(posedge clk); #1;
    end
    idle();
    @(negedge clk);
    checks++;
    if (gnt_cnt0 !== 16'd2 || gnt_cnt1 !== 16'd2) begin
      errors++; $display("FAIL alt_cnt got %0d/%0d want 2/2", gnt_cnt0, gnt_cnt1);
    end
    settle();
    checks++;
    if (q0.size() + q1.size() != 0) begin errors++; $display("FAIL alt_drain got %0d want 0", q0.size() + q1.size()); end
  endtask

  task automatic test_req1_first();
    do_reset();
    req1 = 1; addr1 = 3'd7;
    for (int c = 0; c < 3; c++) begin
      q1.push_back(8'h47);
      @(negedge clk);
      checks++;
      if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
        errors++; $display("FAIL solo1_gnt c%0d got %b%b want 01", c, gnt0, gnt1);
      end
      @(posedge clk); #1;
    end
    req0 = 1; addr0 = 3'd2;
    q0.push_back(8'h42);
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++; $display("FAIL contest_gnt got %b%b want 10", gnt0, gnt1);
    end
    @(posedge clk); #1;
    req0 = 0;
    q1.push_back(8'h47);
    @(negedge clk);
    checks++;
    if (gnt1 !== 1'b1) begin errors++; $display("FAIL contest_next got %b want 1", gnt1); end
    @(posedge clk); #1;
    idle();
    settle();
    checks++;
    if (q0.size() + q1.size() != 0) begin errors++; $display("FAIL solo1_drain got %0d want 0", q0.size() + q1.size()); end
  endtask

  task automatic test_drop();
    do_reset();
    req0 = 1; addr0 = 3'd2; req1 = 1; addr1 = 3'd4;
    q0.push_back(8'h42);
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, mem_addr} !== {1'b1, 1'b0, 3'd2}) begin
      errors++; $display("FAIL drop_gnt got %0h want %0h", {gnt0, gnt1, mem_addr}, {1'b1, 1'b0, 3'd2});
    end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    checks++;
    if (rvalid1 !== 1'b0 || mem_wen !== 1'b0) begin
      errors++; $display("FAIL drop_resp got %b%b want 00", rvalid1, mem_wen);
    end
    settle();
    checks++;
    if (gnt_cnt1 !== 16'd0) begin errors++; $display("FAIL drop_cnt1 got %0d want 0", gnt_cnt1); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req0 = 1; addr0 = 3'd4;
    q0.push_back(8'h44);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    checks++;
    if ({rvalid0, gnt0, gnt_cnt0, mem_wen} !== 19'd0) begin
      errors++; $display("FAIL rst_mid got %0h want 0", {rvalid0, gnt0, gnt_cnt0, mem_wen});
    end
    q0.delete();
    req0 = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (rvalid0 !== 1'b0) begin errors++; $display("FAIL rst_stale got %b want 0", rvalid0); end
    settle();
  endtask

  task automatic test_raw_two_ports();
    do_reset();
    req0 = 1; wen0 = 1; addr0 = 3'd5; wdata0 = 8'h3C;
    req1 = 1; wen1 = 0; addr1 = 3'd5;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, mem_wen} !== 3'b101) begin
      errors++; $display("FAIL raw_first got %b want 101", {gnt0, gnt1, mem_wen});
    end
    @(posedge clk); #1;
    req0 = 0; wen0 = 0;
    q1.push_back(8'h3C);
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, mem_wen} !== 3'b010) begin
      errors++; $display("FAIL raw_second got %b want 010", {gnt0, gnt1, mem_wen});
    end
    @(posedge clk); #1;
    idle();
    settle();
    checks++;
    if (q1.size() != 0) begin errors++; $display("FAIL raw_drain got %0d want 0", q1.size()); end
  endtask

  task automatic test_saturate();
    do_reset();
    req1 = 1; wen1 = 1; addr1 = 3'd0; wdata0 = 8'h00; wdata1 = 8'h99;
    repeat (65535) @(posedge clk);
    #1;
    checks++;
    if (gnt_cnt1 !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %0h want ffff", gnt_cnt1); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (gnt_cnt1 !== 16'hFFFF || gnt_cnt0 !== 16'h0) begin
      errors++; $display("FAIL sat_hold got %0h/%0h want 0/ffff", gnt_cnt0, gnt_cnt1);
    end
    cnt_clr = 1;
    @(negedge clk);
    checks++;
    if (gnt1 !== 1'b1) begin errors++; $display("FAIL clr_gnt got %b want 1", gnt1); end
    @(posedge clk); #1;
    checks++;
    if (gnt_cnt1 !== 16'h0) begin errors++; $display("FAIL clr_cnt got %0h want 0", gnt_cnt1); end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alternate();
    test_req1_first();
    test_drop();
    test_reset_mid();
    test_raw_two_ports();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
